// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 sponge sequencer: absorbs 64-bit lanes, pads, drives an external Keccak round
// datapath for NUM_ROUNDS cycles per permutation and streams squeezed lanes out.
module shake256_sponge_ctrl #(
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned RATE_LANES = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   out_lanes,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          busy,
  output logic          done,
  output logic [1599:0] rf_state_o,
  output logic [4:0]    rf_round_o,
  input  logic [1599:0] rf_state_i
);

  typedef enum logic [2:0] {StIdle, StAbsorb, StPad, StPermute, StSqueeze} state_e;

  localparam logic [4:0]  LastLane  = 5'(RATE_LANES - 1);
  localparam logic [4:0]  LastRound = 5'(NUM_ROUNDS - 1);
  // Lowest bit of the most significant byte of the last rate lane (0x80 padding byte).
  localparam int unsigned PadLsb    = 64 * RATE_LANES - 8;

  state_e          fsm_q, ret_q;
  logic [1599:0]   state_q;
  logic [4:0]      lane_cnt_q, sq_cnt_q;
  logic [15:0]     remaining_q;

  logic            last_partial;
  logic [63:0]     tail_mask, tail_pad, msg_lane;
  logic [10:0]     lane_base, sq_next_base;
  logic [1599:0]   state_absorb, state_pad;

  assign rf_state_o = state_q;

  always_comb begin
    last_partial = in_last && (in_bytes < 4'd8);
    tail_mask    = '0;
    tail_pad     = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < in_bytes)  tail_mask[8*b +: 8] = 8'hFF;
      if (4'(b) == in_bytes) tail_pad[8*b +: 8]  = 8'h1F;
    end
    msg_lane = last_partial ? ((in_data & tail_mask) ^ tail_pad) : in_data;

    lane_base    = {lane_cnt_q, 6'd0};
    sq_next_base = {sq_cnt_q + 5'd1, 6'd0};

    // Partial tail carries both padding bytes in the same cycle.
    state_absorb = state_q;
    state_absorb[lane_base +: 64] = state_q[lane_base +: 64] ^ msg_lane;
    if (last_partial) begin
      state_absorb[PadLsb +: 8] = state_absorb[PadLsb +: 8] ^ 8'h80;
    end

    state_pad = state_q;
    state_pad[lane_base +: 64] = state_q[lane_base +: 64] ^ 64'h1F;
    state_pad[PadLsb +: 8]     = state_pad[PadLsb +: 8] ^ 8'h80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= StIdle;
      ret_q       <= StIdle;
      state_q     <= '0;
      lane_cnt_q  <= '0;
      sq_cnt_q    <= '0;
      remaining_q <= '0;
      rf_round_o  <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q     <= '0;
            lane_cnt_q  <= '0;
            sq_cnt_q    <= '0;
            remaining_q <= out_lanes;
            busy        <= 1'b1;
            in_ready    <= 1'b1;
            fsm_q       <= StAbsorb;
          end
        end

        StAbsorb: begin
          if (in_valid && in_ready) begin
            state_q <= state_absorb;
            if (last_partial) begin
              in_ready   <= 1'b0;
              lane_cnt_q <= '0;
              ret_q      <= StSqueeze;
              fsm_q      <= StPermute;
            end else if (lane_cnt_q == LastLane) begin
              // Block full: permute before padding (if last) or absorbing more.
              in_ready   <= 1'b0;
              lane_cnt_q <= '0;
              ret_q      <= in_last ? StPad : StAbsorb;
              fsm_q      <= StPermute;
            end else begin
              lane_cnt_q <= lane_cnt_q + 5'd1;
              if (in_last) begin
                in_ready <= 1'b0;
                fsm_q    <= StPad;
              end
            end
          end
        end

        StPad: begin
          state_q <= state_pad;
          ret_q   <= StSqueeze;
          fsm_q   <= StPermute;
        end

        StPermute: begin
          state_q <= rf_state_i;
          if (rf_round_o == LastRound) begin
            rf_round_o <= '0;
            fsm_q      <= ret_q;
            case (ret_q)
              StAbsorb: in_ready <= 1'b1;
              StSqueeze: begin
                sq_cnt_q <= '0;
                if (remaining_q != '0) begin
                  out_valid <= 1'b1;
                  out_data  <= rf_state_i[63:0];
                end
              end
              default: ;
            endcase
          end else begin
            rf_round_o <= rf_round_o + 5'd1;
          end
        end

        StSqueeze: begin
          if (remaining_q == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            fsm_q <= StIdle;
          end else if (out_valid && out_ready) begin
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              fsm_q     <= StIdle;
            end else if (sq_cnt_q == LastLane) begin
              out_valid <= 1'b0;
              sq_cnt_q  <= '0;
              ret_q     <= StSqueeze;
              fsm_q     <= StPermute;
            end else begin
              sq_cnt_q <= sq_cnt_q + 5'd1;
              out_data <= state_q[sq_next_base +: 64];
            end
          end
        end

        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_sponge_ctrl.sv
// Bench for shake256_sponge_ctrl: toy round function, sponge reference model and an output
// scoreboard of expected squeezed lanes.
module tb_shake256_sponge_ctrl;

  localparam int NR = 24;
  localparam int RL = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   out_lanes;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          busy;
  logic          done;
  logic [1599:0] rf_state_o;
  logic [4:0]    rf_round_o;
  logic [1599:0] rf_state_i;

  always #5 clk = ~clk;

  // Toy round: rotate whole state, inject a round constant, one nonlinear lane.
  function automatic logic [1599:0] rnd(input logic [1599:0] s, input logic [4:0] r);
    logic [1599:0] o;
    o = {s[1598:0], s[1599]};
    o[63:0]   = o[63:0] ^ 64'h9E3779B97F4A7C15 ^ {59'd0, r};
    o[127:64] = o[127:64] ^ (s[63:0] & s[191:128]);
    return o;
  endfunction

  function automatic logic [1599:0] perm(input logic [1599:0] s);
    logic [1599:0] t;
    t = s;
    for (int r = 0; r < NR; r++) t = rnd(t, 5'(r));
    return t;
  endfunction

  assign rf_state_i = rnd(rf_state_o, rf_round_o);

  shake256_sponge_ctrl #(
    .NUM_ROUNDS(NR),
    .RATE_LANES(RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .out_lanes (out_lanes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .rf_state_o(rf_state_o),
    .rf_round_o(rf_round_o),
    .rf_state_i(rf_state_i)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  logic [63:0]   msg_q[$];
  logic [63:0]   exp_q[$];
  logic [1599:0] exp_pre;
  bit            exp_wrap;
  logic [63:0]   obs_lane0, obs_lane16;

  always @(negedge clk) if (done) done_seen++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_msg(input int n, input logic [63:0] pat, input bit rnd_data);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(rnd_data ? {$urandom, $urandom} : pat);
  endtask

  // Reference sponge: pre-final-permutation state plus expected output lanes.
  task automatic build_expect(input int nb, input int n_out);
    logic [1599:0] st;
    logic [63:0]   last, m;
    int            idx;
    st = '0;
    idx = 0;
    exp_wrap = 1'b0;
    exp_q.delete();
    for (int i = 0; i < msg_q.size() - 1; i++) begin
      st[64*idx +: 64] = st[64*idx +: 64] ^ msg_q[i];
      idx++;
      if (idx == RL) begin
        st = perm(st);
        idx = 0;
      end
    end
    last = msg_q[msg_q.size() - 1];
    if (nb >= 8) begin
      st[64*idx +: 64] = st[64*idx +: 64] ^ last;
      idx++;
      if (idx == RL) begin
        st = perm(st);
        idx = 0;
        exp_wrap = 1'b1;
      end
      st[64*idx +: 64] = st[64*idx +: 64] ^ 64'h1F;
    end else begin
      m = '0;
      for (int b = 0; b < nb; b++) m[8*b +: 8] = last[8*b +: 8];
      m[8*nb +: 8] = 8'h1F;
      st[64*idx +: 64] = st[64*idx +: 64] ^ m;
    end
    st[64*RL-8 +: 8] = st[64*RL-8 +: 8] ^ 8'h80;
    exp_pre = st;
    st = perm(st);
    idx = 0;
    for (int k = 0; k < n_out; k++) begin
      if (idx == RL) begin
        st = perm(st);
        idx = 0;
      end
      exp_q.push_back(st[64*idx +: 64]);
      idx++;
    end
  endtask

  // Starts a message and feeds all lanes; returns 0 on a ready timeout.
  task automatic drive_msg(input int nb, input int n_out, input string name, output bit ok);
    int t;
    ok = 1'b1;
    start = 1'b1;
    out_lanes = 16'(n_out);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq($sformatf("%s:busy after start", name), 64'(busy), 64'd1);
    for (int i = 0; i < msg_q.size(); i++) begin
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      in_bytes = in_last ? 4'(nb) : 4'd8;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check_eq($sformatf("%s:in_ready timeout lane%0d", name, i), 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic run_msg(input int nb, input int n_out, input int stall_at, input string name);
    int          t, dly;
    bit          ok;
    logic [63:0] got, held, exp;
    build_expect(nb, n_out);
    drive_msg(nb, n_out, name, ok);
    if (!ok) return;
    dly = (nb >= 8) ? (exp_wrap ? NR + 1 : 1) : 0;
    repeat (dly) begin
      @(posedge clk); #1;
    end
    check_eq($sformatf("%s:round0", name), 64'(rf_round_o), 64'd0);
    check_eq($sformatf("%s:in_ready in permute", name), 64'(in_ready), 64'd0);
    check_eq($sformatf("%s:out_valid in permute", name), 64'(out_valid), 64'd0);
    for (int j = 0; j < 25; j++)
      check_eq($sformatf("%s:pre lane%0d", name, j), rf_state_o[64*j +: 64], exp_pre[64*j +: 64]);
    obs_lane0  = rf_state_o[63:0];
    obs_lane16 = rf_state_o[64*16 +: 64];

    for (int k = 0; k < n_out; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) begin
        check_eq($sformatf("%s:out_valid timeout lane%0d", name, k), 64'(out_valid), 64'd1);
        return;
      end
      if (k == stall_at) begin
        held = out_data;
        repeat (5) begin
          @(posedge clk); #1;
          check_eq($sformatf("%s:stall valid", name), 64'(out_valid), 64'd1);
          check_eq($sformatf("%s:stall data", name), out_data, held);
        end
      end
      got = out_data;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
      check_eq($sformatf("%s:out lane%0d", name, k), got, exp);
    end
    t = 0;
    while (!done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq($sformatf("%s:done pulse", name), 64'(done), 64'd1);
    check_eq($sformatf("%s:idle busy", name), 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_eq($sformatf("%s:done one cycle", name), 64'(done), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int  t, d0;
    bit  ok;
    rst = 1'b1;
    start = 1'b0;
    out_lanes = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_bytes = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset:in_ready", 64'(in_ready), 64'd0);
    check_eq("reset:out_valid", 64'(out_valid), 64'd0);
    check_eq("reset:out_data", out_data, 64'd0);
    check_eq("reset:busy", 64'(busy), 64'd0);
    check_eq("reset:done", 64'(done), 64'd0);
    check_eq("reset:round", 64'(rf_round_o), 64'd0);
    check_eq("reset:lane0", rf_state_o[63:0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty message: padding only.
    fill_msg(1, 64'hDEADBEEFCAFEF00D, 1'b0);
    run_msg(0, 4, -1, "empty");
    check_eq("empty:lane0 const", obs_lane0, 64'h1F);
    check_eq("empty:lane16 const", obs_lane16, 64'h8000000000000000);

    // Partial tail in lane 16: both padding bytes share the lane.
    fill_msg(17, 64'h1111111111111111, 1'b0);
    run_msg(7, 2, -1, "tail16");
    check_eq("tail16:lane16 const", obs_lane16, 64'h9F11111111111111);

    fill_msg(17, '0, 1'b1);
    run_msg(8, 3, -1, "full17");

    fill_msg(5, '0, 1'b1);
    run_msg(3, 20, -1, "out20");

    fill_msg(3, '0, 1'b1);
    run_msg(8, 6, 2, "stall");

    fill_msg(2, '0, 1'b1);
    run_msg(5, 0, -1, "out0");

    fill_msg(35, '0, 1'b1);
    run_msg(4, 5, -1, "multi");

    // Reset in the middle of a permutation.
    fill_msg(4, '0, 1'b1);
    build_expect(6, 3);
    drive_msg(6, 3, "rstperm", ok);
    if (ok) begin
      t = 0;
      while (rf_round_o != 5'd10 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check_eq("rstperm:reach round10", 64'(rf_round_o), 64'd10);
      d0 = done_seen;
      rst = 1'b1;
      #1;
      check_eq("rstperm:in_ready", 64'(in_ready), 64'd0);
      check_eq("rstperm:out_valid", 64'(out_valid), 64'd0);
      check_eq("rstperm:out_data", out_data, 64'd0);
      check_eq("rstperm:busy", 64'(busy), 64'd0);
      check_eq("rstperm:round", 64'(rf_round_o), 64'd0);
      check_eq("rstperm:lane0", rf_state_o[63:0], 64'd0);
      check_eq("rstperm:lane16", rf_state_o[64*16 +: 64], 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
      end
      check_eq("rstperm:no done", 64'(done_seen), 64'(d0));
      check_eq("rstperm:idle busy", 64'(busy), 64'd0);
      check_eq("rstperm:idle out_valid", 64'(out_valid), 64'd0);
    end

    fill_msg(6, '0, 1'b1);
    run_msg(2, 4, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
